// File: rtl/sext_pkg.sv
// Shared definitions for the miniRV immediate generator: op encodings and legality check.
package sext_pkg;

  localparam int SEXT_OP_W = 4;

  localparam logic [SEXT_OP_W-1:0] SEXT_NONE = 4'd0;
  localparam logic [SEXT_OP_W-1:0] SEXT_I    = 4'd1;
  localparam logic [SEXT_OP_W-1:0] SEXT_S    = 4'd2;
  localparam logic [SEXT_OP_W-1:0] SEXT_B    = 4'd3;
  localparam logic [SEXT_OP_W-1:0] SEXT_J    = 4'd4;
  localparam logic [SEXT_OP_W-1:0] SEXT_U    = 4'd5;
  localparam logic [SEXT_OP_W-1:0] SEXT_Z    = 4'd6;
  localparam logic [SEXT_OP_W-1:0] SEXT_SH   = 4'd7;

  // Encodings 8..15 are reserved and flagged as errors.
  function automatic logic is_legal_op(input logic [SEXT_OP_W-1:0] op);
    return op <= SEXT_SH;
  endfunction

endpackage

// File: rtl/sext_core.sv
// Combinational immediate decode from instruction bits [31:7], extended to XLEN.
module sext_core
  import sext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]          inst_i,
  input  logic [SEXT_OP_W-1:0] sext_op_i,
  output logic [XLEN-1:0]      imme_o,
  output logic                 err_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("sext_core: XLEN must be 32 or 64");
  end

  localparam int SHW = (XLEN == 64) ? 6 : 5;

  // Renumber so field slices read exactly like the ISA manual.
  logic [31:7] ins;
  assign ins = inst_i;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    imme_o = '0;
    err_o  = !is_legal_op(sext_op_i);
    case (sext_op_i)
      SEXT_I:  imme_o = XLEN'($signed(ins[31:20]));
      SEXT_S:  imme_o = XLEN'($signed({ins[31:25], ins[11:7]}));
      SEXT_B:  imme_o = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      SEXT_J:  imme_o = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      SEXT_U:  imme_o = XLEN'($signed({ins[31:12], 12'b0}));
      SEXT_Z:  imme_o = XLEN'(ins[19:15]);
      SEXT_SH: imme_o = XLEN'(ins[20 +: SHW]);
      default: imme_o = '0;
    endcase
  end

endmodule

// File: rtl/sext_pipe.sv
// Registered immediate generator with valid/ready handshake, optional skid entry, tag and flush.
module sext_pipe
  import sext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [24:0]          inst_i,
  input  logic [SEXT_OP_W-1:0] sext_op_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush_i,
  output logic [XLEN-1:0]      imme_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 err_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  typedef struct packed {
    logic [XLEN-1:0]  imme;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [XLEN-1:0] dec_imme;
  logic            dec_err;
  entry_t          in_e;
  entry_t          m_q;
  logic            m_valid_q;
  logic            accept;

  sext_core #(.XLEN(XLEN)) u_core (
    .inst_i    (inst_i),
    .sext_op_i (sext_op_i),
    .imme_o    (dec_imme),
    .err_o     (dec_err)
  );

  assign in_e   = '{imme: dec_imme, tag: tag_i, err: dec_err};
  assign accept = valid_i && ready_o;

  if (SKID != 0) begin : g_skid
    entry_t k_q;
    logic   k_valid_q;

    // Ready depends only on the skid flag, so it never combinationally follows ready_i.
    assign ready_o = !rst_i && !k_valid_q;

    // NOTE: data registers are reset too because the outputs must read zero after reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        m_valid_q <= 1'b0;
        k_valid_q <= 1'b0;
        m_q       <= '0;
        k_q       <= '0;
      end else if (flush_i) begin
        m_valid_q <= 1'b0;
        k_valid_q <= 1'b0;
      end else if (!m_valid_q || ready_i) begin
        if (k_valid_q) begin
          m_q       <= k_q;
          m_valid_q <= 1'b1;
          k_valid_q <= 1'b0;
        end else if (accept) begin
          m_q       <= in_e;
          m_valid_q <= 1'b1;
        end else begin
          m_valid_q <= 1'b0;
        end
      end else if (accept) begin
        k_q       <= in_e;
        k_valid_q <= 1'b1;
      end
    end
  end else begin : g_noskid
    assign ready_o = !rst_i && (!m_valid_q || ready_i);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        m_valid_q <= 1'b0;
        m_q       <= '0;
      end else if (flush_i) begin
        m_valid_q <= 1'b0;
      end else if (!m_valid_q || ready_i) begin
        m_valid_q <= accept;
        if (accept) m_q <= in_e;
      end
    end
  end

  assign valid_o = m_valid_q;
  assign imme_o  = m_q.imme;
  assign tag_o   = m_q.tag;
  assign err_o   = m_q.err;

endmodule

// File: tb/tb_sext_pipe.sv
// Directed bench for sext_pipe: XLEN=32 skid, XLEN=64 skid and XLEN=32 no-skid instances.
module tb_sext_pipe;
  import sext_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: XLEN=32, SKID=1
  logic [24:0] inst_a; logic [3:0] op_a; logic [4:0] tag_a;
  logic valid_a, ready_a, flush_a, rdy_o_a, err_a, vo_a;
  logic [31:0] imme_a; logic [4:0] tago_a;
  // Instance B: XLEN=64, SKID=1
  logic [24:0] inst_b; logic [3:0] op_b; logic [4:0] tag_b;
  logic valid_b, ready_b, rdy_o_b, err_b, vo_b;
  logic [63:0] imme_b; logic [4:0] tago_b;
  // Instance C: XLEN=32, SKID=0
  logic [24:0] inst_c; logic [3:0] op_c; logic [4:0] tag_c;
  logic valid_c, ready_c, rdy_o_c, err_c, vo_c;
  logic [31:0] imme_c; logic [4:0] tago_c;

  sext_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) u_a (
    .clk_i(clk), .rst_i(rst), .inst_i(inst_a), .sext_op_i(op_a), .tag_i(tag_a),
    .valid_i(valid_a), .ready_o(rdy_o_a), .flush_i(flush_a), .imme_o(imme_a),
    .tag_o(tago_a), .err_o(err_a), .valid_o(vo_a), .ready_i(ready_a));

  sext_pipe #(.XLEN(64), .TAG_W(5), .SKID(1)) u_b (
    .clk_i(clk), .rst_i(rst), .inst_i(inst_b), .sext_op_i(op_b), .tag_i(tag_b),
    .valid_i(valid_b), .ready_o(rdy_o_b), .flush_i(1'b0), .imme_o(imme_b),
    .tag_o(tago_b), .err_o(err_b), .valid_o(vo_b), .ready_i(ready_b));

  sext_pipe #(.XLEN(32), .TAG_W(5), .SKID(0)) u_c (
    .clk_i(clk), .rst_i(rst), .inst_i(inst_c), .sext_op_i(op_c), .tag_i(tag_c),
    .valid_i(valid_c), .ready_o(rdy_o_c), .flush_i(1'b0), .imme_o(imme_c),
    .tag_o(tago_c), .err_o(err_c), .valid_o(vo_c), .ready_i(ready_c));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] op, input logic [31:0] w, input logic [4:0] tag);
    op_a = op; inst_a = w[31:7]; tag_a = tag; valid_a = 1'b1;
  endtask

  task automatic drive_b(input logic [3:0] op, input logic [31:0] w, input logic [4:0] tag);
    op_b = op; inst_b = w[31:7]; tag_b = tag; valid_b = 1'b1;
  endtask

  task automatic drive_c(input logic [3:0] op, input logic [31:0] w, input logic [4:0] tag);
    op_c = op; inst_c = w[31:7]; tag_c = tag; valid_c = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    inst_a = '0; op_a = '0; tag_a = '0; valid_a = 1'b0; ready_a = 1'b0; flush_a = 1'b0;
    inst_b = '0; op_b = '0; tag_b = '0; valid_b = 1'b0; ready_b = 1'b0;
    inst_c = '0; op_c = '0; tag_c = '0; valid_c = 1'b0; ready_c = 1'b0;
    #1;
    check("rst_ready_a", rdy_o_a, 0);
    check("rst_ready_c", rdy_o_c, 0);
    tick();
    check("rst_valid_a", vo_a, 0);
    check("rst_imme_a", imme_a, 0);
    check("rst_tag_a", tago_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_imme_b", imme_b, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready_a", rdy_o_a, 1);
    check("post_rst_ready_b", rdy_o_b, 1);
    check("post_rst_ready_c", rdy_o_c, 1);

    // Back-to-back stream of decode patterns, one per cycle.
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b0;
    drive_a(SEXT_I, 32'hFFF00093, 5'd1);
    drive_b(SEXT_U, 32'h80000000, 5'd1);
    drive_c(SEXT_I, 32'h00100093, 5'd1);
    tick();
    check("i_valid", vo_a, 1);
    check("i_imme", imme_a, 64'hFFFFFFFF);
    check("i_err", err_a, 0);
    check("i_tag", tago_a, 1);
    check("u64_imme", imme_b, 64'hFFFFFFFF80000000);
    check("c_valid", vo_c, 1);
    check("c_ready_stalled", rdy_o_c, 0);
    ready_c = 1'b1;
    #1;
    check("c_ready_comb", rdy_o_c, 1);
    drive_c(SEXT_I, 32'h00200093, 5'd2);
    drive_a(SEXT_B, 32'hFE000EE3, 5'd2);
    drive_b(SEXT_SH, 32'h03F00000, 5'd2);
    tick();
    check("b_imme", imme_a, 64'hFFFFFFFC);
    check("b_tag", tago_a, 2);
    check("sh64_imme", imme_b, 64'h3F);
    check("c_tag2", tago_c, 2);
    check("c_imme2", imme_c, 2);
    valid_c = 1'b0;
    drive_a(SEXT_S, 32'hFE000EE3, 5'd3);
    drive_b(SEXT_I, 32'hFFF00093, 5'd3);
    tick();
    check("s_imme", imme_a, 64'hFFFFFFFD);
    check("i64_imme", imme_b, 64'hFFFFFFFFFFFFFFFF);
    check("c_drained", vo_c, 0);
    valid_b = 1'b0;
    drive_a(SEXT_SH, 32'h03F00000, 5'd4);
    tick();
    check("sh32_imme", imme_a, 64'h1F);
    drive_a(SEXT_J, 32'hFFDFF0EF, 5'd5);
    tick();
    check("j_imme", imme_a, 64'hFFFFFFFC);
    drive_a(SEXT_Z, 32'h000A8000, 5'd6);
    tick();
    check("z_imme", imme_a, 64'h15);
    drive_a(SEXT_U, 32'h80000000, 5'd7);
    tick();
    check("u32_imme", imme_a, 64'h80000000);
    drive_a(SEXT_NONE, 32'hFFFFFFFF, 5'd8);
    tick();
    check("none_imme", imme_a, 0);
    check("none_err", err_a, 0);
    drive_a(4'hF, 32'hFFFFFFFF, 5'd9);
    tick();
    check("illegal_imme", imme_a, 0);
    check("illegal_err", err_a, 1);
    check("illegal_tag", tago_a, 9);
    drive_a(SEXT_I, 32'h00100093, 5'd10);
    tick();
    check("legal_after_err", err_a, 0);
    check("legal_after_imme", imme_a, 1);
    valid_a = 1'b0;
    tick();
    check("idle_valid", vo_a, 0);
    check("idle_hold_imme", imme_a, 1);

    // Backpressure: tags 1,2,3 offered while ready_i is low for three cycles.
    ready_a = 1'b0;
    drive_a(SEXT_I, 32'h00100093, 5'd1);
    tick();
    check("bp1_tag", tago_a, 1);
    check("bp1_ready", rdy_o_a, 1);
    drive_a(SEXT_I, 32'h00200093, 5'd2);
    tick();
    check("bp2_ready_low", rdy_o_a, 0);
    check("bp2_tag_stable", tago_a, 1);
    check("bp2_imme_stable", imme_a, 1);
    drive_a(SEXT_I, 32'h00300093, 5'd3);
    tick();
    check("bp3_ready_low", rdy_o_a, 0);
    check("bp3_valid", vo_a, 1);
    check("bp3_imme_stable", imme_a, 1);
    check("bp3_tag_stable", tago_a, 1);
    ready_a = 1'b1;
    tick();
    check("order_tag2", tago_a, 2);
    check("order_imme2", imme_a, 2);
    check("order_ready_back", rdy_o_a, 1);
    tick();
    check("order_tag3", tago_a, 3);
    check("order_valid3", vo_a, 1);
    valid_a = 1'b0;
    tick();
    check("order_empty", vo_a, 0);

    // Flush with M and K both full and an offered input.
    ready_a = 1'b0;
    drive_a(SEXT_I, 32'h00400093, 5'd4);
    tick();
    drive_a(SEXT_I, 32'h00500093, 5'd5);
    tick();
    check("fl_full_ready", rdy_o_a, 0);
    drive_a(SEXT_I, 32'h00600093, 5'd6);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    valid_a = 1'b0;
    ready_a = 1'b1;
    #1;
    check("fl_valid", vo_a, 0);
    check("fl_ready", rdy_o_a, 1);
    check("fl_data_kept", tago_a, 4);
    tick();
    check("fl_no_ghost", vo_a, 0);
    // Flush coinciding with an accepted input drops that input.
    drive_a(SEXT_I, 32'h00700093, 5'd7);
    flush_a = 1'b1;
    #1;
    check("fl2_ready", rdy_o_a, 1);
    tick();
    flush_a = 1'b0;
    valid_a = 1'b0;
    #1;
    check("fl2_valid", vo_a, 0);
    check("fl2_tag_hold", tago_a, 4);
    tick();
    check("fl2_no_ghost", vo_a, 0);

    // Reset with an entry pending.
    ready_a = 1'b0;
    drive_a(SEXT_I, 32'h00800093, 5'd8);
    tick();
    check("pend_valid", vo_a, 1);
    check("pend_tag", tago_a, 8);
    valid_a = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_ready_now", rdy_o_a, 0);
    tick();
    check("mrst_valid", vo_a, 0);
    check("mrst_imme", imme_a, 0);
    check("mrst_tag", tago_a, 0);
    check("mrst_ready", rdy_o_a, 0);
    tick();
    check("mrst_ready_hold", rdy_o_a, 0);
    rst = 1'b0;
    #1;
    check("mrst_ready_after", rdy_o_a, 1);
    check("mrst_valid_after", vo_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sext_pipe.md
Name: sext_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage of the miniRV core.
- Decodes the immediate from instruction bits [31:7] for all RV32I/RV64I formats, plus CSR zimm and shift-amount forms.
- Extends the result to XLEN and registers it behind a valid/ready handshake, with an optional skid buffer, an in-flight tag and a flush.
- Sits between instruction fetch/decode and the ID/EX register; an illegal op raises an error flag instead of holding stale data.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- TAG_W, 5, width of the sideband tag carried with each immediate (rd or ROB index).
- SKID, 1, 1 = two-entry skid buffer with registered ready_o; 0 = single output register.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- inst_i  input  25  instruction bits [31:7].
- sext_op_i  input  4  immediate format select (encodings in package).
- tag_i  input  TAG_W  sideband tag.
- valid_i  input  1  upstream offers an instruction.
- ready_o  output  1  block can accept this cycle.
- flush_i  input  1  discard all buffered entries.
- imme_o  output  XLEN  extended immediate.
- tag_o  output  TAG_W  tag matching imme_o.
- err_o  output  1  the entry at the output had an illegal op.
- valid_o  output  1  output entry valid.
- ready_i  input  1  downstream accepts.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high (rst_i). All state updates on the rising edge.
- Reset values: valid_o=0, imme_o=0, tag_o=0, err_o=0, skid entry empty. ready_o=0 while rst_i=1, and 1 on the first cycle after reset.
- Transfers: accept when valid_i && ready_o; deliver when valid_o && ready_i.
- Latency: 1 cycle from accept to valid_o. Throughput: 1 per cycle when ready_i stays high.
- Extension by op (package names; sx = sign-extend to XLEN, zx = zero-extend):
  - NONE=0: 0.
  - I=1: sx(inst[31:20]).
  - S=2: sx({inst[31:25], inst[11:7]}).
  - B=3: sx({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J=4: sx({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U=5: sx({inst[31:12], 12'b0}); for XLEN=64 bits [63:32] copy bit 31.
  - Z=6: zx(inst[19:15]).
  - SH=7: zx(inst[20 +: log2(XLEN)]), i.e. 5 bits for XLEN=32, 6 bits for XLEN=64.
  - Ops 8–15: illegal; imme=0, err=1. err=0 for every legal op.
- SKID=1 (main register M, skid register K):
  - ready_o = !K.valid (registered).
  - Accept while M is empty or draining: data goes to M.
  - Accept while M.valid && !ready_i: data goes to K; ready_o falls the next cycle.
  - When M drains and K is valid, K moves to M the same edge. Order is strictly preserved.
- SKID=0: ready_o = !valid_o || ready_i (combinational); single register M.
- Stall: while valid_o && !ready_i, imme_o, tag_o and err_o stay bit-stable.
- When valid_o=0, data outputs hold their last value.
- Flush: flush_i=1 clears M.valid and K.valid at the edge. An input accepted in the same cycle is dropped. ready_o=1 the next cycle. Data registers are not cleared.
- Flush takes priority over accept and drain. rst_i takes priority over flush_i.
- Reset mid-stream: all buffered entries are lost; no partial output.
- XLEN outside {32, 64} is an elaboration error.

Decomposition:
- Package sext_pkg holds:
  - SEXT_OP_W=4;
  - op constants SEXT_NONE/I/S/B/J/U/Z/SH;
  - function is_legal_op.
- Sub-module sext_core: purely combinational decode, parametrised by XLEN, outputs imme and err.
- sext_pipe instantiates sext_core and adds the M/K buffering, handshake and flush.

Test Plan:
- I-type: XLEN=32, inst word 0xFFF00093 (addi x1,x0,-1), op I, ready_i=1 -> next cycle valid_o=1, imme_o=0xFFFFFFFF, err_o=0.
- B-type: inst 0xFE000EE3 (beq x0,x0,-4), op B -> imme_o=0xFFFFFFFC. Same inst with op S -> 0xFFFFFFFD.
- U and SH at XLEN=64:
  - inst[31:12]=0x80000, op U -> imme_o=0xFFFFFFFF80000000.
  - inst[25:20]=0x3F, op SH -> 0x3F.
  - XLEN=32, inst[24:20]=0x1F, op SH -> 0x1F.
- Backpressure, SKID=1:
  - Stimulus: stream tags 1,2,3 back-to-back with ready_i=0 for 3 cycles.
  - Required: ready_o=0 after tag 2 is accepted; tag 3 is held upstream.
  - Required: on raising ready_i, tags 1,2,3 emerge in order on consecutive cycles; imme_o is stable throughout the stall.
- Flush: M and K both full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed-cycle input never appears at the output.
- Illegal and reset:
  - op 4'hF -> imme_o=0, err_o=1; a following legal op -> err_o=0.
  - rst_i asserted with an entry pending -> next cycle valid_o=0, imme_o=0, tag_o=0, ready_o=0 until rst_i falls.
